// File: rtl/acq_event_pkg.sv
// Shared definitions for the acquisition event reader: event word layout,
// one-hot state bit indices and the state encoding built from them.
package acq_event_pkg;

    localparam int WORD_W   = 32;
    localparam int NUM_W    = 24;
    localparam int TYPE_W   = 3;
    localparam int RSVD_W   = 5;
    localparam int WDOG_W   = 24;

    localparam int NUM_LSB  = 0;
    localparam int NUM_MSB  = 23;
    localparam int TYPE_LSB = 24;
    localparam int TYPE_MSB = 26;
    localparam int RSVD_LSB = 27;
    localparam int RSVD_MSB = 31;

    localparam int IDLE_BIT    = 0;
    localparam int REQUEST_BIT = 1;
    localparam int READOUT_BIT = 2;
    localparam int RECOVER_BIT = 3;

    typedef enum logic [3:0] {
        S_IDLE    = 4'(1 << IDLE_BIT),
        S_REQUEST = 4'(1 << REQUEST_BIT),
        S_READOUT = 4'(1 << READOUT_BIT),
        S_RECOVER = 4'(1 << RECOVER_BIT)
    } state_e;

    // A word is only usable when every reserved bit is zero.
    function automatic logic word_is_valid(input logic [WORD_W-1:0] w);
        return w[RSVD_MSB:RSVD_LSB] == {RSVD_W{1'b0}};
    endfunction

endpackage

// File: rtl/acq_event_reader_watchdog.sv
// Readout watchdog: counts cycles while running, restarts from zero on clear,
// and flags expiry combinationally on the cycle the count reaches LIMIT-1.
module readout_watchdog
    import acq_event_pkg::*;
#(
    parameter logic [WDOG_W-1:0] LIMIT = 24'd4000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic run_i,
    output logic expire_o
);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = run_i && (cnt_q == LIMIT - 24'd1);

endmodule

// File: rtl/acq_event_reader.sv
// Pops trigger events from the acquisition FIFO and hands each one to the
// command manager as a readout request. Define ACQ_EVT_SEQ_CHECK_EN to add
// trigger-number continuity checking on seq_err_cnt.
module acq_event_reader
    import acq_event_pkg::*;
#(
    parameter logic [WDOG_W-1:0] TIMEOUT_CYCLES = 24'd4000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clr_err,
    input  logic              fifo_valid,
    input  logic [WORD_W-1:0] fifo_data,
    output logic              fifo_ready,
    output logic              readout_req,
    output logic [TYPE_W-1:0] readout_type,
    output logic [NUM_W-1:0]  readout_num,
    input  logic              readout_ack,
    input  logic              readout_done,
    output logic [NUM_W-1:0]  event_cnt,
    output logic              fmt_err,
    output logic              timeout_err,
    output logic [15:0]       seq_err_cnt,
    output logic [3:0]        state
);

    state_e            state_q, state_d;
    logic [TYPE_W-1:0] type_q, type_d;
    logic [NUM_W-1:0]  num_q, num_d;
    logic [NUM_W-1:0]  evt_cnt_q, evt_cnt_d;
    logic              fmt_err_q, fmt_err_d;
    logic              tmo_err_q, tmo_err_d;
    logic              transfer;
    logic              good_xfer;
    logic              bad_xfer;
    logic              expire;

    assign transfer  = fifo_valid & fifo_ready;
    assign good_xfer = transfer & word_is_valid(fifo_data);
    assign bad_xfer  = transfer & ~word_is_valid(fifo_data);

    readout_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear_i (~state_q[READOUT_BIT]),
        .run_i   (state_q[READOUT_BIT]),
        .expire_o(expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Done takes priority over a simultaneous watchdog expiry.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (good_xfer) state_d = S_REQUEST;
            S_REQUEST: if (readout_ack) state_d = S_READOUT;
            S_READOUT: begin
                if (readout_done) begin
                    state_d = S_IDLE;
                end else if (expire) begin
                    state_d = S_RECOVER;
                end
            end
            S_RECOVER: if (readout_done || clr_err) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_ready  = state_q[IDLE_BIT] & enable;
        readout_req = state_q[REQUEST_BIT];
        state       = state_q;
    end

    // Error clears come first so that a fresh error in the same cycle sticks.
    always_comb begin
        type_d    = type_q;
        num_d     = num_q;
        evt_cnt_d = evt_cnt_q;
        fmt_err_d = fmt_err_q;
        tmo_err_d = tmo_err_q;
        if (good_xfer) begin
            type_d = fifo_data[TYPE_MSB:TYPE_LSB];
            num_d  = fifo_data[NUM_MSB:NUM_LSB];
        end
        if (state_q[READOUT_BIT] && readout_done) begin
            evt_cnt_d = evt_cnt_q + 24'd1;
        end
        if (clr_err) begin
            fmt_err_d = 1'b0;
            tmo_err_d = 1'b0;
        end
        if (bad_xfer) begin
            fmt_err_d = 1'b1;
        end
        if (state_q[READOUT_BIT] && expire && !readout_done) begin
            tmo_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            type_q    <= '0;
            num_q     <= '0;
            evt_cnt_q <= '0;
            fmt_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            type_q    <= type_d;
            num_q     <= num_d;
            evt_cnt_q <= evt_cnt_d;
            fmt_err_q <= fmt_err_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign readout_type = type_q;
    assign readout_num  = num_q;
    assign event_cnt    = evt_cnt_q;
    assign fmt_err      = fmt_err_q;
    assign timeout_err  = tmo_err_q;

`ifdef ACQ_EVT_SEQ_CHECK_EN
    logic              armed_q, armed_d;
    logic [NUM_W-1:0]  prev_q, prev_d;
    logic [15:0]       seq_cnt_q, seq_cnt_d;
    logic              seq_gap;

    assign seq_gap = good_xfer && armed_q &&
                     (fifo_data[NUM_MSB:NUM_LSB] != prev_q + 24'd1);

    always_comb begin
        armed_d   = armed_q;
        prev_d    = prev_q;
        seq_cnt_d = seq_cnt_q;
        if (good_xfer) begin
            armed_d = 1'b1;
            prev_d  = fifo_data[NUM_MSB:NUM_LSB];
        end
        if (clr_err) begin
            seq_cnt_d = seq_gap ? 16'd1 : 16'd0;
        end else if (seq_gap && seq_cnt_q != 16'hFFFF) begin
            seq_cnt_d = seq_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed_q   <= 1'b0;
            prev_q    <= '0;
            seq_cnt_q <= '0;
        end else begin
            armed_q   <= armed_d;
            prev_q    <= prev_d;
            seq_cnt_q <= seq_cnt_d;
        end
    end

    assign seq_err_cnt = seq_cnt_q;
`else
    assign seq_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_acq_event_reader.sv
// Self-checking bench for acq_event_reader: directed scenarios followed by
// randomized events, all compared against a transaction-level model.
module tb_acq_event_reader;

    localparam logic [23:0] TMO = 24'd16;

    localparam logic [3:0] ST_IDLE    = 4'b0001;
    localparam logic [3:0] ST_REQUEST = 4'b0010;
    localparam logic [3:0] ST_READOUT = 4'b0100;
    localparam logic [3:0] ST_RECOVER = 4'b1000;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        clr_err;
    logic        fifo_valid;
    logic [31:0] fifo_data;
    logic        fifo_ready;
    logic        readout_req;
    logic [2:0]  readout_type;
    logic [23:0] readout_num;
    logic        readout_ack;
    logic        readout_done;
    logic [23:0] event_cnt;
    logic        fmt_err;
    logic        timeout_err;
    logic [15:0] seq_err_cnt;
    logic [3:0]  state;

    int errors = 0;
    int checks = 0;

    logic [23:0] mEventCnt;
    logic        mFmtErr;
    logic        mTmoErr;
    int          mSeqErr;
    logic        mArmed;
    logic [23:0] mPrevNum;
    logic [2:0]  mType;
    logic [23:0] mNum;

    acq_event_reader #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .clr_err     (clr_err),
        .fifo_valid  (fifo_valid),
        .fifo_data   (fifo_data),
        .fifo_ready  (fifo_ready),
        .readout_req (readout_req),
        .readout_type(readout_type),
        .readout_num (readout_num),
        .readout_ack (readout_ack),
        .readout_done(readout_done),
        .event_cnt   (event_cnt),
        .fmt_err     (fmt_err),
        .timeout_err (timeout_err),
        .seq_err_cnt (seq_err_cnt),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] expSeq();
`ifdef ACQ_EVT_SEQ_CHECK_EN
        return 16'(mSeqErr);
`else
        return 16'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, ".event_cnt"}, 32'(event_cnt), 32'(mEventCnt));
        checkOutput({tag, ".fmt_err"}, 32'(fmt_err), 32'(mFmtErr));
        checkOutput({tag, ".timeout_err"}, 32'(timeout_err), 32'(mTmoErr));
        checkOutput({tag, ".seq_err_cnt"}, 32'(seq_err_cnt), 32'(expSeq()));
    endtask

    task automatic modelReset();
        mEventCnt = '0;
        mFmtErr   = 1'b0;
        mTmoErr   = 1'b0;
        mSeqErr   = 0;
        mArmed    = 1'b0;
        mPrevNum  = '0;
        mType     = '0;
        mNum      = '0;
    endtask

    task automatic modelClear();
        mFmtErr = 1'b0;
        mTmoErr = 1'b0;
        mSeqErr = 0;
    endtask

    task automatic applyClear(input string tag);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        modelClear();
        checkStatus(tag);
    endtask

    // Offers one word in IDLE and checks the immediate consequence.
    task automatic applyStimulus(input string tag, input logic [31:0] word);
        logic [23:0] nextNum;
        fifo_valid = 1'b1;
        fifo_data  = word;
        checkOutput({tag, ".ready"}, 32'(fifo_ready), 32'd1);
        tick();
        fifo_valid = 1'b0;
        if (word[31:27] != 5'd0) begin
            mFmtErr = 1'b1;
            checkOutput({tag, ".state"}, 32'(state), 32'(ST_IDLE));
            checkOutput({tag, ".req"}, 32'(readout_req), 32'd0);
        end else begin
            nextNum = mPrevNum + 24'd1;
            if (mArmed && word[23:0] != nextNum && mSeqErr < 65535) mSeqErr++;
            mArmed   = 1'b1;
            mPrevNum = word[23:0];
            mType    = word[26:24];
            mNum     = word[23:0];
            checkOutput({tag, ".state"}, 32'(state), 32'(ST_REQUEST));
            checkOutput({tag, ".req"}, 32'(readout_req), 32'd1);
            checkOutput({tag, ".type"}, 32'(readout_type), 32'(mType));
            checkOutput({tag, ".num"}, 32'(readout_num), 32'(mNum));
        end
        checkStatus(tag);
    endtask

    task automatic waitAck(input string tag, input int ackDelay);
        for (int i = 0; i < ackDelay; i++) begin
            tick();
            checkOutput({tag, ".req_hold"}, 32'(readout_req), 32'd1);
            checkOutput({tag, ".type_hold"}, 32'(readout_type), 32'(mType));
            checkOutput({tag, ".num_hold"}, 32'(readout_num), 32'(mNum));
        end
        readout_ack = 1'b1;
        tick();
        readout_ack = 1'b0;
        checkOutput({tag, ".readout"}, 32'(state), 32'(ST_READOUT));
        checkOutput({tag, ".req_drop"}, 32'(readout_req), 32'd0);
    endtask

    // Done is raised on the READOUT cycle whose watchdog count is doneDelay.
    task automatic runReadout(input string tag, input int ackDelay, input int doneDelay);
        waitAck(tag, ackDelay);
        for (int i = 0; i < doneDelay; i++) begin
            tick();
            checkOutput({tag, ".busy"}, 32'(state), 32'(ST_READOUT));
        end
        readout_done = 1'b1;
        tick();
        readout_done = 1'b0;
        mEventCnt = mEventCnt + 24'd1;
        checkOutput({tag, ".idle"}, 32'(state), 32'(ST_IDLE));
        checkStatus(tag);
    endtask

    task automatic runTimeout(input string tag, input logic exitByClear);
        waitAck(tag, 0);
        for (int i = 0; i < 15; i++) tick();
        checkOutput({tag, ".last_readout"}, 32'(state), 32'(ST_READOUT));
        checkOutput({tag, ".tmo_pending"}, 32'(timeout_err), 32'(mTmoErr));
        tick();
        mTmoErr = 1'b1;
        checkOutput({tag, ".recover"}, 32'(state), 32'(ST_RECOVER));
        checkStatus(tag);
        if (exitByClear) begin
            clr_err = 1'b1;
            tick();
            clr_err = 1'b0;
            modelClear();
        end else begin
            readout_done = 1'b1;
            tick();
            readout_done = 1'b0;
        end
        checkOutput({tag, ".exit"}, 32'(state), 32'(ST_IDLE));
        checkStatus(tag);
    endtask

    task automatic applyReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        modelReset();
        tick();
    endtask

    logic [31:0] word;
    logic [23:0] rndNum;

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        clr_err      = 1'b0;
        fifo_valid   = 1'b0;
        fifo_data    = '0;
        readout_ack  = 1'b0;
        readout_done = 1'b0;
        modelReset();
        tick();
        tick();
        checkOutput("rst.state", 32'(state), 32'(ST_IDLE));
        checkOutput("rst.req", 32'(readout_req), 32'd0);
        checkOutput("rst.type", 32'(readout_type), 32'd0);
        checkOutput("rst.num", 32'(readout_num), 32'd0);
        checkOutput("rst.ready_dis", 32'(fifo_ready), 32'd0);
        checkStatus("rst");
        reset  = 1'b0;
        enable = 1'b1;
        tick();
        checkOutput("rst.ready_en", 32'(fifo_ready), 32'd1);

        applyStimulus("basic", 32'h0300_0005);
        checkOutput("basic.type3", 32'(readout_type), 32'd3);
        checkOutput("basic.num5", 32'(readout_num), 32'd5);
        runReadout("basic", 2, 3);
        checkOutput("basic.cnt1", 32'(event_cnt), 32'd1);

        applyStimulus("fmt", 32'h0800_0001);
        tick();
        checkOutput("fmt.no_req", 32'(readout_req), 32'd0);
        applyClear("fmt_clr");

        readout_done = 1'b1;
        tick();
        readout_done = 1'b0;
        checkOutput("done_idle.state", 32'(state), 32'(ST_IDLE));
        checkStatus("done_idle");

        applyStimulus("done_req", 32'h0100_0006);
        readout_done = 1'b1;
        tick();
        readout_done = 1'b0;
        checkOutput("done_req.state", 32'(state), 32'(ST_REQUEST));
        checkStatus("done_req");
        runReadout("done_req", 0, 1);

        applyStimulus("tmo_done", 32'h0200_0007);
        runTimeout("tmo_done", 1'b0);
        applyStimulus("tmo_clr", 32'h0400_0008);
        runTimeout("tmo_clr", 1'b1);

        fifo_valid = 1'b1;
        fifo_data  = 32'hF000_0000;
        clr_err    = 1'b1;
        tick();
        fifo_valid = 1'b0;
        clr_err    = 1'b0;
        modelClear();
        mFmtErr = 1'b1;
        checkStatus("clr_vs_new");
        applyClear("clr_vs_new_clr");

        applyStimulus("edge_done", 32'h0500_0009);
        runReadout("edge_done", 0, 15);

        applyStimulus("enable", 32'h0600_000A);
        enable = 1'b0;
        runReadout("enable", 1, 2);
        checkOutput("enable.ready_off", 32'(fifo_ready), 32'd0);
        fifo_valid = 1'b1;
        fifo_data  = 32'h0000_000B;
        tick();
        tick();
        fifo_valid = 1'b0;
        checkOutput("enable.blocked", 32'(state), 32'(ST_IDLE));
        checkOutput("enable.no_req", 32'(readout_req), 32'd0);
        enable = 1'b1;
        tick();

        applyReset();
        applyStimulus("seq10", 32'h0000_000A);
        runReadout("seq10", 0, 0);
        applyStimulus("seq11", 32'h0000_000B);
        runReadout("seq11", 0, 0);
        applyStimulus("seq13", 32'h0000_000D);
        runReadout("seq13", 0, 0);
        applyStimulus("seq14", 32'h0000_000E);
        runReadout("seq14", 0, 0);
`ifdef ACQ_EVT_SEQ_CHECK_EN
        checkOutput("seq.one_gap", 32'(seq_err_cnt), 32'd1);
`endif
        applyStimulus("seqFFFFFF", 32'h00FF_FFFF);
        runReadout("seqFFFFFF", 0, 0);
        applyStimulus("seq0", 32'h0000_0000);
        runReadout("seq0", 0, 0);

        applyStimulus("midrst", 32'h0700_0020);
        waitAck("midrst", 1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("midrst.state", 32'(state), 32'(ST_IDLE));
        checkOutput("midrst.req", 32'(readout_req), 32'd0);
        checkOutput("midrst.type", 32'(readout_type), 32'd0);
        checkOutput("midrst.num", 32'(readout_num), 32'd0);
        checkStatus("midrst");
        tick();
        reset = 1'b0;
        #1;
        checkOutput("midrst.ready", 32'(fifo_ready), 32'd1);
        tick();
        tick();
        checkOutput("midrst.no_reissue", 32'(readout_req), 32'd0);
        checkOutput("midrst.idle", 32'(state), 32'(ST_IDLE));

        for (int n = 0; n < 30; n++) begin
            rndNum = ($urandom_range(0, 3) == 0) ? 24'($urandom) : mPrevNum + 24'd1;
            word = {5'd0, 3'($urandom_range(0, 7)), rndNum};
            if ($urandom_range(0, 3) == 0) word[31:27] = 5'($urandom_range(1, 31));
            applyStimulus("rnd", word);
            if (word[31:27] == 5'd0) begin
                if ($urandom_range(0, 5) == 0) begin
                    runTimeout("rnd_tmo", 1'($urandom_range(0, 1)));
                end else begin
                    runReadout("rnd_rd", $urandom_range(0, 3), $urandom_range(0, 15));
                end
            end
            if ($urandom_range(0, 4) == 0) applyClear("rnd_clr");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
